// File: rtl/cpu_bus_pkg.sv
// Shared types, constants and the address decoder for the cpu_core bus controller.
package cpu_bus_pkg;

  localparam int ADDR_MAX = 32;
  localparam logic [15:0] DEFAULT_PER_BASE = 16'hF000;
  localparam logic [15:0] BUS_ERR_DATA = 16'hDEAD;

  typedef enum logic [1:0] {IDLE, MEM_WAIT, PER_WAIT, ACK} bus_state_t;
  typedef enum logic {REG_MEM, REG_PER} region_t;

  // Callers zero-extend their bus-width address to ADDR_MAX bits.
  function automatic region_t decode_region(input logic [ADDR_MAX-1:0] addr,
                                            input logic [ADDR_MAX-1:0] base);
    return (addr >= base) ? REG_PER : REG_MEM;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Loadable wait-state down-counter shared by the SRAM and peripheral wait paths.
// Latency: flags follow the count one cycle after load/enable; no backpressure, it only counts.
module bus_wait_timer #(
  parameter int CW = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          load,
  input  logic [CW-1:0] loadVal,
  input  logic          enable,
  output logic          expireOne,
  output logic          expireZero
);

  logic [CW-1:0] count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expireOne  = (count == CW'(1));
  assign expireZero = (count == '0);

endmodule

// File: rtl/cpu_bus_ctrl.sv
// Bus controller behind cpu_core: latches the address, decodes SRAM vs peripheral, returns read data.
// Latency: nWait low MEM_WS cycles for SRAM, until PerReady or PER_TIMEOUT for peripherals; backpressure via nWait.
module cpu_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int            DW          = 16,
  parameter int            MEM_WS      = 2,
  parameter logic [DW-1:0] PER_BASE    = DW'(DEFAULT_PER_BASE),
  parameter int            PER_TIMEOUT = 8,
  parameter logic [DW-1:0] ERR_DATA    = DW'(BUS_ERR_DATA)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [DW-1:0] DataOut,
  input  logic          Ale,
  input  logic          nMe,
  input  logic          RnW,
  input  logic          nOe,
  input  logic          Enb,
  output logic [DW-1:0] DataIn,
  output logic          nWait,
  output logic [DW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  output logic          MemCe,
  output logic          MemWe,
  output logic          PerSel,
  input  logic [DW-1:0] PerRData,
  input  logic          PerReady,
  output logic          BusErr
);

  localparam int CW = 8;

  bus_state_t    state;
  region_t       region;
  logic          addrValid;
  logic          startAcc;
  logic          memDone;
  logic          tmrEnable;
  logic [CW-1:0] tmrLoadVal;
  logic          tmrOne;
  logic          tmrZero;
  logic          unusedProto;

  // nOe/Enb are protocol observability only; they never gate the datapath.
  assign unusedProto = nOe ^ Enb;

  assign region     = decode_region(ADDR_MAX'(MemAddr), ADDR_MAX'(PER_BASE));
  assign startAcc   = (state == IDLE) && !nMe && !Ale && addrValid;
  assign tmrLoadVal = (region == REG_PER) ? CW'(PER_TIMEOUT) : CW'(MEM_WS);
  assign tmrEnable  = (state == MEM_WAIT) || (state == PER_WAIT);
  assign memDone    = (startAcc && (region == REG_MEM) && (MEM_WS == 0)) ||
                      ((state == MEM_WAIT) && !nMe && tmrOne);

  bus_wait_timer #(.CW(CW)) uTimer (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (startAcc),
    .loadVal    (tmrLoadVal),
    .enable     (tmrEnable),
    .expireOne  (tmrOne),
    .expireZero (tmrZero)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      addrValid <= 1'b0;
      DataIn    <= '0;
      nWait     <= 1'b1;
      MemAddr   <= '0;
      MemWData  <= '0;
      MemCe     <= 1'b0;
      MemWe     <= 1'b0;
      PerSel    <= 1'b0;
      BusErr    <= 1'b0;
    end else begin
      MemWe <= 1'b0;
      if (Ale) begin
        MemAddr   <= DataOut;
        addrValid <= 1'b1;
      end
      // SRAM completion: capture read data or issue the single write strobe.
      if (memDone) begin
        if (RnW) begin
          DataIn <= MemRData;
        end else begin
          MemWData <= DataOut;
          MemWe    <= 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (startAcc) begin
            if (region == REG_PER) begin
              PerSel <= 1'b1;
              nWait  <= 1'b0;
              state  <= PER_WAIT;
            end else begin
              MemCe <= 1'b1;
              if (MEM_WS == 0) begin
                state <= ACK;
              end else begin
                nWait <= 1'b0;
                state <= MEM_WAIT;
              end
            end
          end
        end
        MEM_WAIT: begin
          if (nMe) begin
            nWait <= 1'b1;
            MemCe <= 1'b0;
            state <= IDLE;
          end else if (tmrOne) begin
            nWait <= 1'b1;
            state <= ACK;
          end
        end
        PER_WAIT: begin
          if (nMe) begin
            nWait  <= 1'b1;
            PerSel <= 1'b0;
            state  <= IDLE;
          end else if (PerReady) begin
            if (RnW) DataIn <= PerRData;
            nWait  <= 1'b1;
            PerSel <= 1'b0;
            state  <= ACK;
          end else if (tmrOne || tmrZero) begin
            if (RnW) DataIn <= ERR_DATA;
            BusErr <= 1'b1;
            nWait  <= 1'b1;
            PerSel <= 1'b0;
            state  <= ACK;
          end
        end
        ACK: begin
          MemCe <= 1'b0;
          if (nMe) begin
            state <= IDLE;
            if (!Ale) addrValid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Scoreboard bench: two controllers (MEM_WS=2 and MEM_WS=0) share stimulus; a monitor checks each completed access.
module tb_cpu_bus_ctrl;

  localparam int NDUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dataOut;
  logic        ale, nMe, rnW, nOe, enb, perReady;
  logic [15:0] memRData, perRData;

  logic [15:0] dataIn   [NDUT];
  logic [15:0] memAddr  [NDUT];
  logic [15:0] memWData [NDUT];
  logic        nWait    [NDUT];
  logic        memCe    [NDUT];
  logic        memWe    [NDUT];
  logic        perSel   [NDUT];
  logic        busErr   [NDUT];

  always #5 clk = ~clk;

  cpu_bus_ctrl #(.MEM_WS(2)) u0 (
    .Clock(clk), .Reset(rst), .DataOut(dataOut), .Ale(ale), .nMe(nMe), .RnW(rnW),
    .nOe(nOe), .Enb(enb), .DataIn(dataIn[0]), .nWait(nWait[0]), .MemAddr(memAddr[0]),
    .MemWData(memWData[0]), .MemRData(memRData), .MemCe(memCe[0]), .MemWe(memWe[0]),
    .PerSel(perSel[0]), .PerRData(perRData), .PerReady(perReady), .BusErr(busErr[0])
  );

  cpu_bus_ctrl #(.MEM_WS(0)) u1 (
    .Clock(clk), .Reset(rst), .DataOut(dataOut), .Ale(ale), .nMe(nMe), .RnW(rnW),
    .nOe(nOe), .Enb(enb), .DataIn(dataIn[1]), .nWait(nWait[1]), .MemAddr(memAddr[1]),
    .MemWData(memWData[1]), .MemRData(memRData), .MemCe(memCe[1]), .MemWe(memWe[1]),
    .PerSel(perSel[1]), .PerRData(perRData), .PerReady(perReady), .BusErr(busErr[1])
  );

  typedef struct {
    logic [15:0] addr;
    logic        isPer;
    int          waitCnt;
    int          selCnt;
    int          weCnt;
    logic [15:0] wdata;
    logic [15:0] data;
    logic        err;
  } exp_t;

  // One directed access with its hand-computed response (wait0: MEM_WS=2 unit, wait1: MEM_WS=0 unit).
  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          readyAt;
    int          abortAt;
    logic        same;
    logic        isPer;
    int          wait0;
    int          wait1;
    int          sel;
    int          we;
    logic [15:0] data;
    logic        err;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[10];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic        inRec [NDUT];
  logic        mGot  [NDUT];
  logic        mPer  [NDUT];
  int          mWait [NDUT];
  int          mSel  [NDUT];
  int          mWe   [NDUT];
  logic [15:0] mWdata[NDUT];
  logic [15:0] mData [NDUT];

  task automatic finalize(input int d);
    exp_t e;
    if (!mGot[d]) mData[d] = dataIn[d];
    inRec[d] = 1'b0;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      chk("unexpected_access", d, 32'(memAddr[d]), 32'hFFFF_FFFF);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk("addr", d, 32'(memAddr[d]), 32'(e.addr));
    chk("region", d, 32'(mPer[d]), 32'(e.isPer));
    chk("nwait_low_cycles", d, mWait[d], e.waitCnt);
    chk("persel_cycles", d, mSel[d], e.selCnt);
    chk("memwe_pulses", d, mWe[d], e.weCnt);
    if (e.weCnt != 0) chk("memwdata", d, 32'(mWdata[d]), 32'(e.wdata));
    chk("datain", d, 32'(mData[d]), 32'(e.data));
    chk("buserr", d, 32'(busErr[d]), 32'(e.err));
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) inRec[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (rst) begin
          inRec[d] = 1'b0;
        end else if (inRec[d] && !(memCe[d] || perSel[d])) begin
          finalize(d);
        end else if (memCe[d] || perSel[d]) begin
          if (!inRec[d]) begin
            inRec[d] = 1'b1;
            mGot[d] = 1'b0;
            mPer[d] = perSel[d];
            mWait[d] = 0;
            mSel[d] = 0;
            mWe[d] = 0;
            mWdata[d] = '0;
          end
          if (!nWait[d]) mWait[d]++;
          if (perSel[d]) mSel[d]++;
          if (memWe[d]) begin
            mWe[d]++;
            mWdata[d] = memWData[d];
          end
          if (nWait[d] && !mGot[d]) begin
            mGot[d] = 1'b1;
            mData[d] = dataIn[d];
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic runVec(input vec_t v);
    exp_t e;
    bit   done;
    for (int d = 0; d < NDUT; d++) begin
      e.addr = v.addr; e.isPer = v.isPer; e.waitCnt = (d == 0) ? v.wait0 : v.wait1;
      e.selCnt = v.sel; e.weCnt = v.we; e.wdata = v.wdata; e.data = v.data; e.err = v.err;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    ale = 1'b1; dataOut = v.addr; memRData = v.rdata; perRData = v.rdata;
    if (v.same) begin nMe = 1'b0; rnW = v.rnw; end
    tick();
    if (v.same)
      for (int d = 0; d < NDUT; d++) chk("ale_nme_same_cycle", d, {memCe[d], perSel[d], nWait[d]}, 3'b001);
    ale = 1'b0; nMe = 1'b0; rnW = v.rnw; enb = !v.rnw; nOe = !v.rnw;
    dataOut = v.rnw ? 16'h0000 : v.wdata;
    tick();
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (nWait[0] && nWait[1]) begin
        done = 1'b1;
      end else if (c == v.abortAt) begin
        nMe = 1'b1;
        tick();
        done = 1'b1;
      end else begin
        perReady = (c == v.readyAt);
        tick();
      end
    end
    if (!done) chk("access_completes_in_budget", 0, 32'(done), 32'd1);
    nMe = 1'b1; perReady = 1'b0; enb = 1'b0; nOe = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    //           addr     rnw wdata     rdata     rdy ab same per w0 w1 sel we data      err
    vecs[0] = '{16'h0100, 1, 16'h0000, 16'h1234, 0, 0, 0, 0, 2, 0, 0, 0, 16'h1234, 0};
    vecs[1] = '{16'h0200, 0, 16'hBEEF, 16'h0000, 0, 0, 0, 0, 2, 0, 0, 1, 16'h1234, 0};
    vecs[2] = '{16'hF004, 1, 16'h0000, 16'h00A5, 3, 0, 0, 1, 3, 3, 3, 0, 16'h00A5, 0};
    vecs[3] = '{16'hEFFF, 1, 16'h0000, 16'h5A5A, 0, 0, 0, 0, 2, 0, 0, 0, 16'h5A5A, 0};
    vecs[4] = '{16'hF000, 0, 16'h7777, 16'h0000, 1, 0, 0, 1, 1, 1, 1, 0, 16'h5A5A, 0};
    vecs[5] = '{16'hF008, 1, 16'h0000, 16'h1111, 0, 2, 0, 1, 2, 2, 2, 0, 16'h5A5A, 0};
    vecs[6] = '{16'hF010, 1, 16'h0000, 16'h3333, 0, 0, 0, 1, 8, 8, 8, 0, 16'hDEAD, 1};
    vecs[7] = '{16'h0120, 1, 16'h0000, 16'h4321, 0, 0, 0, 0, 2, 0, 0, 0, 16'h4321, 1};
    vecs[8] = '{16'h0300, 1, 16'h0000, 16'h0F0F, 0, 0, 1, 0, 2, 0, 0, 0, 16'h0F0F, 1};
    vecs[9] = '{16'h0500, 1, 16'h0000, 16'h2222, 0, 0, 0, 0, 2, 0, 0, 0, 16'h2222, 0};

    rst = 1'b1; dataOut = '0; ale = 1'b0; nMe = 1'b1; rnW = 1'b1; nOe = 1'b1; enb = 1'b0;
    memRData = '0; perRData = '0; perReady = 1'b0;
    tick();
    tick();
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_datain", d, 32'(dataIn[d]), 0);
      chk("reset_outputs", d, {nWait[d], memCe[d], memWe[d], perSel[d], busErr[d]}, 5'b10000);
      chk("reset_memaddr", d, 32'(memAddr[d]), 0);
      chk("reset_memwdata", d, 32'(memWData[d]), 0);
    end
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) runVec(vecs[i]);

    // Reset lands in the middle of an SRAM wait.
    ale = 1'b1; dataOut = 16'h0400; tick();
    ale = 1'b0; nMe = 1'b0; rnW = 1'b1; memRData = 16'h9999; tick();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) chk("reset_async", d, {nWait[d], memCe[d], perSel[d]}, 3'b100);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int d = 0; d < NDUT; d++) chk("nme_without_ale_ignored", d, {memCe[d], perSel[d], nWait[d]}, 3'b001);
    end
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_clears_buserr", d, 32'(busErr[d]), 0);
      chk("reset_clears_datain", d, 32'(dataIn[d]), 0);
    end
    nMe = 1'b1;
    tick();
    runVec(vecs[9]);

    repeat (4) tick();
    chk("scoreboard_drained", 0, q0.size(), 0);
    chk("scoreboard_drained", 1, q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_ctrl.md
Name: cpu_bus_ctrl

Overview:
- Bus controller directly downstream of cpu_core. It consumes the core's multiplexed bus strobes (Ale, nMe, RnW, nOe, Enb) and its DataOut bus.
- It latches the address, decodes it into a memory region and a peripheral region, and generates wait states back to the core on nWait.
- It returns read data to the core on DataIn and drives a synchronous SRAM port and a simple peripheral select/ready port.

Parameters:
- DW, 16, data/address width.
- MEM_WS, 2, fixed memory wait states (0..15).
- PER_BASE, 16'hF000, first address of the peripheral region; addresses at or above it decode as peripheral.
- PER_TIMEOUT, 8, maximum cycles to wait for PerReady before a bus error (1..255).
- ERR_DATA, 16'hDEAD, read data returned on a peripheral timeout.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- DataOut  in  DW  core output bus: address while Ale=1, write data otherwise.
- Ale  in  1  address latch enable from the core.
- nMe  in  1  memory/IO access strobe, active low.
- RnW  in  1  1=read, 0=write; valid while nMe=0.
- nOe  in  1  core output enable, active low; qualifies DataIn usage.
- Enb  in  1  core drives DataOut (write data phase).
- DataIn  out  DW  registered read data to the core.
- nWait  out  1  wait request to the core, active low.
- MemAddr  out  DW  latched address to SRAM.
- MemWData  out  DW  write data to SRAM.
- MemRData  in  DW  SRAM read data, valid one cycle after MemCe.
- MemCe  out  1  SRAM chip enable.
- MemWe  out  1  SRAM write strobe; one-cycle pulse.
- PerSel  out  1  peripheral access select.
- PerRData  in  DW  peripheral read data.
- PerReady  in  1  peripheral completion.
- BusErr  out  1  sticky flag: a peripheral access timed out.

Behaviour:
- Reset (async, immediate, also mid-operation): DataIn=0, nWait=1, MemAddr=0, MemWData=0, MemCe=0, MemWe=0, PerSel=0, BusErr=0, state=IDLE, counter=0, addr_valid=0.
- Address latch: on a rising edge with Ale=1, MemAddr<=DataOut and addr_valid<=1. Ale takes priority. An access is never started in a cycle where Ale=1, even if nMe=0.
- States: IDLE, MEM_WAIT, PER_WAIT, ACK.
- IDLE, nMe=0, Ale=0, addr_valid=1:
  - MemAddr<PER_BASE: MemCe<=1. If MEM_WS=0, go to ACK. Otherwise load counter=MEM_WS, drive nWait<=0, go to MEM_WAIT.
  - MemAddr>=PER_BASE: PerSel<=1, nWait<=0, counter=PER_TIMEOUT, go to PER_WAIT.
- MEM_WAIT: counter decrements each cycle. At counter==1, nWait<=1 and go to ACK. nWait is therefore low for exactly MEM_WS cycles.
- ACK entry from memory:
  - Read: DataIn<=MemRData.
  - Write: MemWData<=DataOut and MemWe=1 for exactly the first ACK cycle.
  - MemCe<=0 after the first ACK cycle.
- PER_WAIT:
  - PerReady=1: read gives DataIn<=PerRData; nWait<=1, PerSel<=0, go to ACK.
  - Counter reaches 0 without PerReady: DataIn<=ERR_DATA on a read, BusErr<=1, nWait<=1, PerSel<=0, go to ACK.
  - PerReady and timeout in the same cycle: PerReady wins, no error.
- ACK: hold DataIn stable. When nMe=1, clear addr_valid and go to IDLE. A back-to-back access needs a new Ale.
- Abort: nMe=1 in MEM_WAIT or PER_WAIT sends the FSM to IDLE next cycle with nWait=1, MemCe=0, PerSel=0. No MemWe is issued and BusErr is unchanged.
- nMe=0 while addr_valid=0: ignored; stay in IDLE with nWait=1.
- BusErr clears only on Reset.
- DataIn updates only on a read completion. nOe and Enb are monitored for protocol only and do not gate outputs.

Decomposition:
- Package cpu_bus_pkg holds:
  - typedef enum bus_state_t {IDLE, MEM_WAIT, PER_WAIT, ACK};
  - typedef enum region_t {REG_MEM, REG_PER};
  - constants DEFAULT_PER_BASE and BUS_ERR_DATA;
  - function decode_region(addr, base).
- One sub-module, bus_wait_timer, holds the loadable down-counter with load, enable and expire (==1 / ==0) outputs. It is shared by the memory and peripheral wait paths.

Test Plan:
- Memory read, MEM_WS=2: Ale with DataOut=16'h0100, then nMe=0, RnW=1, MemRData=16'h1234 -> nWait low exactly 2 cycles, DataIn=16'h1234 on the cycle nWait returns high, MemAddr=16'h0100.
- Memory write, MEM_WS=0: Ale with 16'h0200, then nMe=0, RnW=0, DataOut=16'hBEEF -> nWait never low, single-cycle MemWe with MemWData=16'hBEEF.
- Peripheral read: address 16'hF004, PerReady asserted on the 3rd wait cycle with PerRData=16'h00A5 -> PerSel high 3 cycles, DataIn=16'h00A5, BusErr=0.
- Peripheral timeout, PER_TIMEOUT=8: address 16'hF010, PerReady held 0 -> nWait low 8 cycles, DataIn=16'hDEAD, BusErr=1 and stays set across later accesses.
- Ale and nMe=0 in the same cycle -> no MemCe, no nWait; access starts the following cycle.
- Reset asserted mid-MEM_WAIT -> nWait=1, MemCe=0, state IDLE immediately; nMe=0 after reset is ignored until a new Ale.
